// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration chain loader.
// Pure declarations: no logic, no latency.
// Backpressure is not applicable here.
package cfg_chain_pkg;

    // Load sequencer states, in the order a normal load visits them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Level driven onto the chain R pins while the chain is being cleared.
    localparam logic CHAIN_CLR_ACTIVE = 1'b0;

    // Width of a counter that has to reach max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Loadable right-shift register that hands config words out LSB-first, with a per-word bit count.
// bit_out is a look-ahead: it is the bit that sits at the LSB after the current edge.
// No backpressure: the owner decides when to load or shift.
module cfg_word_serializer
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data_in,
    output logic              bit_out,
    output logic              last
);

    localparam int              CW       = cnt_width(WORD_W);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WORD_W - 1);

    logic [WORD_W-1:0] r_shreg;
    logic [CW-1:0]     r_word_cnt;
    logic [WORD_W-1:0] w_shifted;

    assign w_shifted = r_shreg >> 1;

    // Capture a fresh word on load, otherwise drop the LSB that was just sent on each shift.
    always_ff @(posedge clk) begin
        if (R) begin
            r_shreg    <= '0;
            r_word_cnt <= '0;
        end else if (load) begin
            r_shreg    <= data_in;
            r_word_cnt <= '0;
        end else if (shift) begin
            r_shreg    <= w_shifted;
            r_word_cnt <= r_word_cnt + CW'(1);
        end
    end

    // The owner registers this into chain_d, so it must already show the post-edge LSB.
    assign bit_out = load ? data_in[0] : w_shifted[0];

    // The shift happening in this cycle is the final bit of the current word.
    assign last = (r_word_cnt == LAST_IDX);

endmodule

// File: rtl/cfg_chain_loader.sv
// Clears a serial config flop chain, then shifts stream words into it LSB-first; done after CHAIN_LEN bits.
// All outputs registered; one WAIT cycle per word plus one chain_e cycle per bit.
// in_ready only in WAIT; optional even-parity check on words under CFG_CHAIN_PARITY_EN.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN  = 64,
    parameter int WORD_W     = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
`ifdef CFG_CHAIN_PARITY_EN
    input  logic              in_parity,
    output logic              par_err,
`endif
    output logic              in_ready,
    output logic              chain_d,
    output logic              chain_e,
    output logic              chain_r,
    output logic              busy,
    output logic              done
);

    localparam int              BW       = cnt_width(CHAIN_LEN);
    localparam int              CLRW     = cnt_width(CLR_CYCLES);
    localparam logic [BW-1:0]   BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [BW-1:0]   r_bit_cnt;
    logic [CLRW-1:0] r_clr_cnt;

    logic r_in_ready;
    logic r_chain_d;
    logic r_chain_e;
    logic r_chain_r;
    logic r_busy;
    logic r_done;

    logic w_hs;
    logic w_par_bad;
    logic w_load;
    logic w_shift;
    logic w_ser_bit;
    logic w_word_last;

    // A word is offered and the registered ready says we are taking it this cycle.
    assign w_hs = (r_state == WAIT) && in_valid && r_in_ready;

`ifdef CFG_CHAIN_PARITY_EN
    assign w_par_bad = ((^in_data) != in_parity);
`else
    assign w_par_bad = 1'b0;
`endif

    // Bad-parity words and words arriving alongside abort never reach the shift register.
    assign w_load  = w_hs && !w_par_bad && !abort;
    assign w_shift = (r_state == SHIFT);

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk     (clk),
        .R       (R),
        .load    (w_load),
        .shift   (w_shift),
        .data_in (in_data),
        .bit_out (w_ser_bit),
        .last    (w_word_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides start and the word handshake.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next = CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        w_next = WAIT;
                    end
                end
                WAIT: begin
                    if (w_hs) begin
                        w_next = w_par_bad ? IDLE : SHIFT;
                    end
                end
                SHIFT: begin
                    // Chain length wins over word length, so a partial last word stops early.
                    if (r_bit_cnt == BIT_LAST) begin
                        w_next = DONE;
                    end else if (w_word_last) begin
                        w_next = WAIT;
                    end
                end
                DONE: begin
                    w_next = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // Clear-duration and chain-bit counters; the bit count restarts with every clear.
    always_ff @(posedge clk) begin
        if (R) begin
            r_clr_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + CLRW'(1);
                r_bit_cnt <= '0;
            end else begin
                r_clr_cnt <= '0;
                if (w_shift) begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (R) begin
            r_in_ready <= 1'b0;
            r_chain_d  <= 1'b0;
            r_chain_e  <= 1'b0;
            r_chain_r  <= ~CHAIN_CLR_ACTIVE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_next == WAIT);
            r_chain_e  <= (w_next == SHIFT);
            r_chain_d  <= (w_next == SHIFT) && w_ser_bit;
            r_chain_r  <= (w_next == CLEAR) ? CHAIN_CLR_ACTIVE : ~CHAIN_CLR_ACTIVE;
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
        end
    end

`ifdef CFG_CHAIN_PARITY_EN
    logic r_par_err;

    // Sticky parity flag: set by a rejected word, cleared by reset or the next accepted start.
    always_ff @(posedge clk) begin
        if (R) begin
            r_par_err <= 1'b0;
        end else if ((r_state == IDLE) && start && !abort) begin
            r_par_err <= 1'b0;
        end else if (w_hs && w_par_bad && !abort) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`endif

    assign in_ready = r_in_ready;
    assign chain_d  = r_chain_d;
    assign chain_e  = r_chain_e;
    assign chain_r  = r_chain_r;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
module tb_cfg_chain_loader;

    localparam int CHAIN_LEN  = 10;
    localparam int WORD_W     = 4;
    localparam int CLR_CYCLES = 2;
    localparam int NWORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk = 1'b0;
    logic              R;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              chain_d;
    logic              chain_e;
    logic              chain_r;
    logic              busy;
    logic              done;
`ifdef CFG_CHAIN_PARITY_EN
    logic              in_parity;
    logic              par_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cfg_chain_loader #(
        .CHAIN_LEN  (CHAIN_LEN),
        .WORD_W     (WORD_W),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk       (clk),
        .R         (R),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef CFG_CHAIN_PARITY_EN
        .in_parity (in_parity),
        .par_err   (par_err),
`endif
        .in_ready  (in_ready),
        .chain_d   (chain_d),
        .chain_e   (chain_e),
        .chain_r   (chain_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the chain sees the words' bits LSB-first, concatenated, cut at CHAIN_LEN.
    logic [WORD_W-1:0] words  [NWORDS];
    int                stalls [NWORDS];

    function automatic int exp_bit(input int i);
        logic [WORD_W-1:0] w;
        w = words[i / WORD_W];
        return int'(w[i % WORD_W]);
    endfunction

    // Monitor: what the chain actually received.
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   clr_n, done_n, e_n, last_e_cyc, done_cyc;
    logic got_bits [$];

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (chain_e) begin
                got_bits.push_back(chain_d);
                e_n++;
                last_e_cyc = cyc;
            end else begin
                check_val("d_quiet", int'(chain_d), 0);
            end
            check_val("e_rdy_excl", int'(chain_e & in_ready), 0);
            if (chain_r == 1'b0) clr_n++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic mon_reset();
        got_bits.delete();
        clr_n = 0; done_n = 0; e_n = 0; last_e_cyc = -10; done_cyc = -20;
        mon_en = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int stall,
                             input bit par_bad, input bit poke, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("rdy_timeout", 0, 1);
            ok = 1'b0;
            return;
        end
        if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check_val("poke_wait_rdy", int'(in_ready), 1);
            check_val("poke_wait_r", int'(chain_r), 1);
        end
        repeat (stall) begin
            check_val("stall_rdy", int'(in_ready), 1);
            check_val("stall_e", int'(chain_e), 0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = w;
`ifdef CFG_CHAIN_PARITY_EN
        in_parity = (^w) ^ par_bad;
`endif
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (poke && !par_bad) begin
            @(negedge clk);
            check_val("poke_shift_e", int'(chain_e), 1);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = done;
    endtask

    task automatic run_load(input string tag, input int poke_idx);
        bit ok, seen;
        mon_reset();
        pulse_start();
        for (int k = 0; k < NWORDS; k++) begin
            send_word(words[k], stalls[k], 1'b0, (k == poke_idx), ok);
            if (!ok) break;
        end
        wait_done(seen);
        check_val({tag, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        check_val({tag, "_busy_after"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check_val({tag, "_e_count"}, e_n, CHAIN_LEN);
        for (int i = 0; i < CHAIN_LEN && i < got_bits.size(); i++)
            check_val($sformatf("%s_bit%0d", tag, i), int'(got_bits[i]), exp_bit(i));
        check_val({tag, "_clr_cycles"}, clr_n, CLR_CYCLES);
        check_val({tag, "_done_count"}, done_n, 1);
        check_val({tag, "_done_timing"}, done_cyc, last_e_cyc + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rdy"}, int'(in_ready), 0);
        check_val({tag, "_d"}, int'(chain_d), 0);
        check_val({tag, "_e"}, int'(chain_e), 0);
        check_val({tag, "_r"}, int'(chain_r), 1);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
    endtask

    task automatic wait_shifts(input int cnt, input string tag);
        int seen_e, n;
        seen_e = 0;
        n = 0;
        while (seen_e < cnt && n < 50) begin
            @(negedge clk);
            if (chain_e) seen_e++;
            n++;
        end
        check_val({tag, "_reach"}, seen_e, cnt);
    endtask

    initial begin
        bit ok;
        R = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef CFG_CHAIN_PARITY_EN
        in_parity = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 R = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Directed load: 0xA, 0x5, 0x3 with the stream always ready.
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
        stalls[0] = 0; stalls[1] = 0; stalls[2] = 0;
        run_load("dir", -1);

        // Same words, five-cycle stall before the second word.
        stalls[1] = 5;
        run_load("stall", -1);

        // start pokes while in WAIT and SHIFT must not disturb the load.
        stalls[1] = 0;
        run_load("poke", 1);

        // Abort on the third shift of the first word.
        mon_reset();
        pulse_start();
        send_word($urandom_range(0, 15), 0, 1'b0, 1'b0, ok);
        wait_shifts(3, "abort");
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check_val("abort_e", int'(chain_e), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_rdy", int'(in_ready), 0);
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        check_val("abort_no_done", done_n, 0);
        check_val("abort_e_count", e_n, 3);
        for (int k = 0; k < NWORDS; k++) words[k] = WORD_W'($urandom_range(0, 15));
        run_load("restart", -1);

        // Reset pulse mid-SHIFT with start raised in the same cycle.
        pulse_start();
        send_word(4'h6, 0, 1'b0, 1'b0, ok);
        wait_shifts(2, "rst");
        R = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 R = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check_val("rst_start_ignored", int'(busy), 0);

        // Randomised loads.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NWORDS; k++) begin
                words[k]  = WORD_W'($urandom_range(0, 15));
                stalls[k] = $urandom_range(0, 3);
            end
            run_load($sformatf("rnd%0d", r), (r == 3) ? 0 : -1);
        end

`ifdef CFG_CHAIN_PARITY_EN
        // Parity: 0x5 carries even parity 0, so in_parity=1 must be rejected.
        mon_reset();
        pulse_start();
        send_word(4'h5, 0, 1'b1, 1'b0, ok);
        @(negedge clk);
        check_val("par_err_set", int'(par_err), 1);
        check_val("par_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check_val("par_no_shift", e_n, 0);
        check_val("par_no_done", done_n, 0);
        pulse_start();
        @(negedge clk);
        check_val("par_err_clr", int'(par_err), 0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
        stalls[0] = 0; stalls[1] = 0; stalls[2] = 0;
        run_load("par_ok", -1);
        check_val("par_err_stays_clr", int'(par_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
